mem2axi: RTL

Single-outstanding AXI4 initiator that turns a simple req/gnt/rvalid memory port into single-beat AXI read and write transactions on an `AXI_BUS.Master` port. It is the initiator-side counterpart of `axi2mem`: harness-side DMA/loader agents and small peripherals use it to drive the crossbar's slave ports. Each accepted request becomes exactly one AXI transaction. The response comes back as a registered one-cycle `rvalid_o` pulse.

---
 rtl/mem2axi_pkg.sv | 8 +
 rtl/axi_bus.sv | 74 +++++++
 rtl/mem2axi.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mem2axi_pkg.sv
// mem2axi_pkg: shared AXI4 constants (response codes, burst types) used by mem2axi and axi2mem.
package mem2axi_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;
endpackage

// File: rtl/axi_bus.sv
// AXI_BUS: AXI4 bus bundle with Master and Slave modports.
//   AXI_ADDR_WIDTH/AXI_DATA_WIDTH/AXI_ID_WIDTH/AXI_USER_WIDTH size the five channels.
interface AXI_BUS #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 10,
    parameter int AXI_USER_WIDTH = 1
);
    logic [AXI_ID_WIDTH-1:0]     aw_id;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]                  aw_len;
    logic [2:0]                  aw_size;
    logic [1:0]                  aw_burst;
    logic                        aw_lock;
    logic [3:0]                  aw_cache;
    logic [2:0]                  aw_prot;
    logic [3:0]                  aw_qos;
    logic [3:0]                  aw_region;
    logic [5:0]                  aw_atop;
    logic [AXI_USER_WIDTH-1:0]   aw_user;
    logic                        aw_valid;
    logic                        aw_ready;
    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_last;
    logic [AXI_USER_WIDTH-1:0]   w_user;
    logic                        w_valid;
    logic                        w_ready;
    logic [AXI_ID_WIDTH-1:0]     b_id;
    logic [1:0]                  b_resp;
    logic [AXI_USER_WIDTH-1:0]   b_user;
    logic                        b_valid;
    logic                        b_ready;
    logic [AXI_ID_WIDTH-1:0]     ar_id;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]                  ar_len;
    logic [2:0]                  ar_size;
    logic [1:0]                  ar_burst;
    logic                        ar_lock;
    logic [3:0]                  ar_cache;
    logic [2:0]                  ar_prot;
    logic [3:0]                  ar_qos;
    logic [3:0]                  ar_region;
    logic [AXI_USER_WIDTH-1:0]   ar_user;
    logic                        ar_valid;
    logic                        ar_ready;
    logic [AXI_ID_WIDTH-1:0]     r_id;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic                        r_last;
    logic [AXI_USER_WIDTH-1:0]   r_user;
    logic                        r_valid;
    logic                        r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid, input aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
        input b_id, b_resp, b_user, b_valid, output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid, input ar_ready,
        input r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
    );

    modport Slave (
        input aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
              aw_qos, aw_region, aw_atop, aw_user, aw_valid, output aw_ready,
        input w_data, w_strb, w_last, w_user, w_valid, output w_ready,
        output b_id, b_resp, b_user, b_valid, input b_ready,
        input ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
              ar_qos, ar_region, ar_user, ar_valid, output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
    );
endinterface

// File: rtl/mem2axi.sv
// mem2axi: single-outstanding AXI4 initiator turning a req/gnt/rvalid memory port into single-beat AXI reads/writes.
//   clk_i, rst_ni (async active-low)
//   req_i/gnt_o/we_i/addr_i/be_i/wdata_i : request port, gnt_o = req_i while idle
//   rvalid_o/rdata_o/err_o               : one-cycle registered response pulse, data/err hold
//   busy_o                               : a transaction is in flight
//   master                               : AXI_BUS.Master port
//   Define MEM2AXI_ALIGN_EN to clear the sub-word bits of aw_addr/ar_addr.
module mem2axi
    import mem2axi_pkg::*;
#(
    parameter int                    AXI_ID_WIDTH   = 10,
    parameter int                    AXI_ADDR_WIDTH = 64,
    parameter int                    AXI_DATA_WIDTH = 64,
    parameter int                    AXI_USER_WIDTH = 1,
    parameter logic [AXI_ID_WIDTH-1:0] AXI_ID       = '0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        req_i,
    output logic                        gnt_o,
    input  logic                        we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
    input  logic [AXI_DATA_WIDTH-1:0]   wdata_i,
    output logic                        rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
    output logic                        err_o,
    output logic                        busy_o,
    AXI_BUS.Master                      master
);
    localparam int OFF = $clog2(AXI_DATA_WIDTH / 8);

    typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA} state_e;

    state_e                        state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0]     addr_q, addr_d, axi_addr;
    logic [AXI_DATA_WIDTH/8-1:0]   be_q, be_d;
    logic [AXI_DATA_WIDTH-1:0]     wdata_q, wdata_d, rdata_q, rdata_d;
    logic                          aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                          rvalid_q, rvalid_d, err_q, err_d;
    logic                          aw_valid, w_valid, b_ready, ar_valid, r_ready;
    logic                          unused_ok;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        gnt_o     = 1'b0;
        aw_valid  = 1'b0;
        w_valid   = 1'b0;
        b_ready   = 1'b0;
        ar_valid  = 1'b0;
        r_ready   = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_o = req_i;
                if (req_i) begin
                    addr_d  = addr_i;
                    be_d    = be_i;
                    wdata_d = wdata_i;
                    state_d = we_i ? WR_ADDR_DATA : RD_ADDR;
                end
            end
            WR_ADDR_DATA: begin
                // AW and W are independent; sticky flags remember which has completed
                aw_valid  = !aw_done_q;
                w_valid   = !w_done_q;
                aw_done_d = aw_done_q | (aw_valid & master.aw_ready);
                w_done_d  = w_done_q | (w_valid & master.w_ready);
                if (aw_done_d && w_done_d) begin
                    state_d   = WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            WR_RESP: begin
                b_ready = 1'b1;
                if (master.b_valid) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b1;
                    rdata_d  = '0;
                    err_d    = master.b_resp[1];
                end
            end
            RD_ADDR: begin
                ar_valid = 1'b1;
                if (master.ar_ready) state_d = RD_DATA;
            end
            RD_DATA: begin
                r_ready = 1'b1;
                if (master.r_valid && master.r_last) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b1;
                    rdata_d  = master.r_data;
                    err_d    = master.r_resp[1];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

`ifdef MEM2AXI_ALIGN_EN
    assign axi_addr = addr_q & ~AXI_ADDR_WIDTH'((1 << OFF) - 1);
`else
    assign axi_addr = addr_q;
`endif

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;
    assign busy_o   = state_q != IDLE;

    assign master.aw_id     = AXI_ID;
    assign master.aw_addr   = axi_addr;
    assign master.aw_len    = 8'd0;
    assign master.aw_size   = 3'(OFF);
    assign master.aw_burst  = BURST_INCR;
    assign master.aw_lock   = 1'b0;
    assign master.aw_cache  = 4'd0;
    assign master.aw_prot   = 3'd0;
    assign master.aw_qos    = 4'd0;
    assign master.aw_region = 4'd0;
    assign master.aw_atop   = 6'd0;
    assign master.aw_user   = '0;
    assign master.aw_valid  = aw_valid;
    assign master.w_data    = wdata_q;
    assign master.w_strb    = be_q;
    assign master.w_last    = 1'b1;
    assign master.w_user    = '0;
    assign master.w_valid   = w_valid;
    assign master.b_ready   = b_ready;
    assign master.ar_id     = AXI_ID;
    assign master.ar_addr   = axi_addr;
    assign master.ar_len    = 8'd0;
    assign master.ar_size   = 3'(OFF);
    assign master.ar_burst  = BURST_INCR;
    assign master.ar_lock   = 1'b0;
    assign master.ar_cache  = 4'd0;
    assign master.ar_prot   = 3'd0;
    assign master.ar_qos    = 4'd0;
    assign master.ar_region = 4'd0;
    assign master.ar_user   = '0;
    assign master.ar_valid  = ar_valid;
    assign master.r_ready   = r_ready;

    // IDs are not checked with a single transaction outstanding; only resp[1] classifies errors
    assign unused_ok = ^{master.b_id, master.b_user, master.b_resp[0],
                         master.r_id, master.r_user, master.r_resp[0]};
endmodule
